mio_bus_ctrl: RTL and testbench

MIO_BUS_CTRL -- requirements
Module: mio_bus_ctrl

---
 rtl/mio_pkg.sv | 39 +++
 rtl/mio_counter.sv | 40 ++++
 rtl/mio_bus_ctrl.sv | 150 +++++++++++++++
 tb/tb_mio_bus_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mio_pkg.sv
// Shared definitions for the MIO bus controller: address map, FSM encoding,
// access decode and the default RAM latency.
package mio_pkg;

  localparam int RAM_LAT_DEF = 1;

  localparam logic [31:0] RAM_LAST = 32'h0000_0FFF;
  localparam logic [31:0] LED_ADDR = 32'hE000_0000;
  localparam logic [31:0] SW_ADDR  = 32'hF000_0000;
  localparam logic [31:0] CNT_ADDR = 32'hF000_0004;
  localparam logic [31:0] CMP_ADDR = 32'hF000_0008;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAM_ACC,
    ST_RAM_WAIT,
    ST_RESP
  } mio_state_e;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_LED,
    SEL_SW,
    SEL_CNT,
    SEL_CMP,
    SEL_NONE
  } mio_sel_e;

  // Map a byte address onto the target it selects
  function automatic mio_sel_e mio_decode(input logic [31:0] a);
    if (a <= RAM_LAST) return SEL_RAM;
    if (a == LED_ADDR) return SEL_LED;
    if (a == SW_ADDR)  return SEL_SW;
    if (a == CNT_ADDR) return SEL_CNT;
    if (a == CMP_ADDR) return SEL_CMP;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/mio_counter.sv
// Free-running 32-bit counter with a compare register and a match pulse.
// Only instantiated when MIO_COUNTER_EN is defined.
module mio_counter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cnt_we_i,
  input  logic        cmp_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] cnt_o,
  output logic [31:0] cmp_o,
  output logic        irq_o
);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cmp_q, cmp_d;

  // A CPU load replaces that cycle's increment; the increment wraps naturally
  always_comb begin
    cnt_d = cnt_we_i ? wdata_i : cnt_q + 32'd1;
    cmp_d = cmp_we_i ? wdata_i : cmp_q;
  end

  // Counter and compare state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      cmp_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      cmp_q <= cmp_d;
    end
  end

  // The counter only sits on the compare value for one cycle, so this is a pulse;
  // a zero compare means "disarmed"
  assign irq_o = (cnt_q == cmp_q) && (cmp_q != 32'd0);
  assign cnt_o = cnt_q;
  assign cmp_o = cmp_q;

endmodule

// File: rtl/mio_bus_ctrl.sv
// CPU-to-memory/IO bus controller: 4 KiB RAM window, LED register, switch
// inputs and (with MIO_COUNTER_EN defined) a counter/compare/irq block.
// Without MIO_COUNTER_EN the counter addresses read as 0 and ignore writes.
module mio_bus_ctrl
  import mio_pkg::*;
#(
  parameter int RAM_LAT = RAM_LAT_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_ready_o,
  output logic        ram_en_o,
  output logic        ram_we_o,
  output logic [9:0]  ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i,
  input  logic [15:0] sw_in_i,
  output logic [15:0] led_out_o,
  output logic        cnt_irq_o
);

  localparam logic [3:0] WAIT_INIT = 4'(RAM_LAT - 1);

  mio_state_e  state_q;
  logic [3:0]  wait_q;
  logic [9:0]  addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        ready_q, ram_en_q, ram_we_q;
  logic [15:0] led_q, led_d;

  logic        start;
  mio_sel_e    sel;
  logic [31:0] io_rdata;

  // A new access is only accepted from IDLE; decode acts on the live address
  assign start = (state_q == ST_IDLE) && cpu_req_i;
  assign sel   = mio_decode(cpu_addr_i);

`ifdef MIO_COUNTER_EN
  logic [31:0] cnt_val, cmp_val;
  logic        cnt_we, cmp_we;

  assign cnt_we = start && cpu_we_i && (sel == SEL_CNT);
  assign cmp_we = start && cpu_we_i && (sel == SEL_CMP);

  mio_counter u_counter (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .cnt_we_i (cnt_we),
    .cmp_we_i (cmp_we),
    .wdata_i  (cpu_wdata_i),
    .cnt_o    (cnt_val),
    .cmp_o    (cmp_val),
    .irq_o    (cnt_irq_o)
  );
`else
  assign cnt_irq_o = 1'b0;
`endif

  // I/O read mux; unmapped (and disabled counter) addresses read as zero
  always_comb begin
    io_rdata = '0;
    case (sel)
      SEL_LED: io_rdata = {16'h0, led_q};
      SEL_SW:  io_rdata = {16'h0, sw_in_i};
`ifdef MIO_COUNTER_EN
      SEL_CNT: io_rdata = cnt_val;
      SEL_CMP: io_rdata = cmp_val;
`endif
      default: io_rdata = '0;
    endcase
  end

  // LED register takes the low half of a write on the IDLE->RESP edge
  always_comb begin
    led_d = led_q;
    if (start && cpu_we_i && (sel == SEL_LED)) led_d = cpu_wdata_i[15:0];
  end

  // LED register state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) led_q <= '0;
    else         led_q <= led_d;
  end

  // Access FSM with registered bus/CPU strobes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      wait_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      ram_en_q <= 1'b0;
      ram_we_q <= 1'b0;
    end else begin
      ready_q  <= 1'b0;
      ram_en_q <= 1'b0;
      ram_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cpu_req_i) begin
            addr_q  <= cpu_addr_i[11:2];
            wdata_q <= cpu_wdata_i;
            if (sel == SEL_RAM) begin
              state_q  <= ST_RAM_ACC;
              ram_en_q <= 1'b1;
              ram_we_q <= cpu_we_i;
            end else begin
              state_q <= ST_RESP;
              ready_q <= 1'b1;
              if (!cpu_we_i) rdata_q <= io_rdata;
            end
          end
        end
        ST_RAM_ACC: begin
          state_q <= ST_RAM_WAIT;
          wait_q  <= WAIT_INIT;
        end
        ST_RAM_WAIT: begin
          if (wait_q == 4'd0) begin
            state_q <= ST_RESP;
            ready_q <= 1'b1;
            rdata_q <= ram_rdata_i;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cpu_rdata_o = rdata_q;
  assign cpu_ready_o = ready_q;
  assign ram_en_o    = ram_en_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;
  assign led_out_o   = led_q;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Scoreboard bench for mio_bus_ctrl (RAM_LAT=1) with a behavioural RAM.
module tb_mio_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready, ram_en, ram_we, cnt_irq;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [15:0] sw_in, led_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_cnt = 0;
  logic [9:0] last_addr;
  logic       last_we;
  int irq_cnt = 0;
  int irq_cyc = -1;

  typedef struct {
    logic [31:0] rd;
    bit          chk;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  logic [31:0] mem [1024];

  always #5 clk = ~clk;

  mio_bus_ctrl #(.RAM_LAT(1)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cpu_req_i   (cpu_req),
    .cpu_we_i    (cpu_we),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .cpu_rdata_o (cpu_rdata),
    .cpu_ready_o (cpu_ready),
    .ram_en_o    (ram_en),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata),
    .sw_in_i     (sw_in),
    .led_out_o   (led_out),
    .cnt_irq_o   (cnt_irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle-latency synchronous RAM
  always @(posedge clk) begin
    if (ram_en) begin
      en_cnt    <= en_cnt + 1;
      last_addr <= ram_addr;
      last_we   <= ram_we;
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  // Monitor: every cpu_ready pulse must match the oldest expected response
  always @(negedge clk) begin
    if (rst_n && cnt_irq) begin
      irq_cnt = irq_cnt + 1;
      irq_cyc = cyc;
    end
    if (rst_n && cpu_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_ready", 32'(cpu_ready), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("ready_cycle", 32'(cyc), 32'(e.cyc));
        if (e.chk) chk("cpu_rdata", cpu_rdata, e.rd);
      end
    end
  end

  task automatic wait_ready();
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (cpu_ready) seen = 1;
    end
    if (!seen) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  // Issue one access from IDLE at a falling edge; lat counts edges from the sampling edge
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input bit chk_rd, input int lat,
                      input int exp_en, input bit drop);
    int en0;
    en0 = en_cnt;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    sbq.push_back('{rd: exp_rd, chk: chk_rd, cyc: cyc + lat});
    if (drop) begin
      @(negedge clk);
      cpu_req = 1'b0;
    end
    wait_ready();
    cpu_req = 1'b0;
    @(negedge clk);
    chk("ram_en_count", 32'(en_cnt - en0), 32'(exp_en));
  endtask

  initial begin
    int lcyc;
    int irq0;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; sw_in = 16'h00FF;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cpu_ready), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_led", 32'(led_out), 32'd0);
    chk("rst_irq", 32'(cnt_irq), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // RAM write (request dropped after sampling) then read back
    xact(1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0, 1'b0, 3, 1, 1'b1);
    chk("ram_addr_wr", 32'(last_addr), 32'd4);
    chk("ram_we_wr", 32'(last_we), 32'd1);
    xact(1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 1'b1, 3, 1, 1'b0);
    chk("ram_addr_rd", 32'(last_addr), 32'd4);
    chk("ram_we_rd", 32'(last_we), 32'd0);
    chk("rdata_held", cpu_rdata, 32'h1234_5678);

    // LED, switches, unmapped
    xact(1'b1, 32'hE000_0000, 32'h0000_A5A5, 32'h0, 1'b0, 1, 0, 1'b0);
    chk("led_out", 32'(led_out), 32'h0000_A5A5);
    xact(1'b0, 32'hF000_0000, 32'h0, 32'h0000_00FF, 1'b1, 1, 0, 1'b0);
    xact(1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 1, 0, 1'b0);
    xact(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1, 0, 1'b0);
    chk("led_after_unmapped_wr", 32'(led_out), 32'h0000_A5A5);
    xact(1'b0, 32'hE000_0000, 32'h0, 32'h0000_A5A5, 1'b1, 1, 0, 1'b0);

`ifdef MIO_COUNTER_EN
    xact(1'b1, 32'hF000_0004, 32'h0000_1000, 32'h0, 1'b0, 1, 0, 1'b0);
    xact(1'b1, 32'hF000_0008, 32'd100, 32'h0, 1'b0, 1, 0, 1'b0);
    xact(1'b0, 32'hF000_0008, 32'h0, 32'd100, 1'b1, 1, 0, 1'b0);
    irq0 = irq_cnt;
    lcyc = cyc + 1;
    xact(1'b1, 32'hF000_0004, 32'd90, 32'h0, 1'b0, 1, 0, 1'b0);
    repeat (15) @(negedge clk);
    chk("irq_pulses", 32'(irq_cnt - irq0), 32'd1);
    chk("irq_cycle", 32'(irq_cyc), 32'(lcyc + 10));
    // Load all-ones, then a read sampled on the first IDLE edge sees the wrap
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'hF000_0004; cpu_wdata = 32'hFFFF_FFFF;
    sbq.push_back('{rd: 32'h0, chk: 1'b0, cyc: cyc + 1});
    wait_ready();
    cpu_we = 1'b0;
    sbq.push_back('{rd: 32'h0, chk: 1'b1, cyc: cyc + 2});
    wait_ready();
    cpu_req = 1'b0;
    @(negedge clk);
`else
    xact(1'b0, 32'hF000_0004, 32'h0, 32'h0, 1'b1, 1, 0, 1'b0);
    xact(1'b1, 32'hF000_0008, 32'd5, 32'h0, 1'b0, 1, 0, 1'b0);
    xact(1'b0, 32'hF000_0008, 32'h0, 32'h0, 1'b1, 1, 0, 1'b0);
    chk("irq_never", 32'(irq_cnt), 32'd0);
`endif

    // Reset while in RAM_WAIT: outputs clear at once, no ready for that access
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010;
    @(negedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(cpu_ready), 32'd0);
    chk("arst_ram_en", 32'(ram_en), 32'd0);
    chk("arst_rdata", cpu_rdata, 32'd0);
    chk("arst_led", 32'(led_out), 32'd0);
    chk("arst_irq", 32'(cnt_irq), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("pending_after_reset", 32'(sbq.size()), 32'd0);
    xact(1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 1'b1, 3, 1, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
